// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with filtered clock, watchdog and valid/ready output
// Optional output FIFO selected by PS2_RX_FIFO_EN; otherwise a single holding register.
module ps2_rx_frame #(
  parameter int FILTER_STEPS   = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 4,
  localparam int LW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ps2c,
  input  logic          ps2d,
  input  logic          rx_ready,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  output logic          rx_parity_err,
  output logic          rx_frame_err,
  output logic          overrun,
  output logic          timeout,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                    c_s1, c_s2, d_s1, d_s2;
  logic [FILTER_STEPS-1:0] filt_sr;
  logic                    filt_clk, filt_prev, fall;

  state_t       state, state_nx;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt;
  logic         par_bit;
  logic [WDW-1:0] wd_cnt;
  logic         wd_hit, push, tmo_now, pop;
  logic [9:0]   push_entry, head;

  // PS/2 lines idle high, so synchronisers and filter reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1      <= 1'b1;
      c_s2      <= 1'b1;
      d_s1      <= 1'b1;
      d_s2      <= 1'b1;
      filt_sr   <= '1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      c_s1      <= ps2c;
      c_s2      <= c_s1;
      d_s1      <= ps2d;
      d_s2      <= d_s1;
      filt_sr   <= {filt_sr[FILTER_STEPS-2:0], c_s2};
      if (&filt_sr)
        filt_clk <= 1'b1;
      else if (~|filt_sr)
        filt_clk <= 1'b0;
      filt_prev <= filt_clk;
    end
  end

  assign fall       = filt_prev & ~filt_clk;
  assign wd_hit     = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
  assign push_entry = {shreg, ~^{shreg, par_bit}, ~d_s2};

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    tmo_now  = 1'b0;
    case (state)
      IDLE: if (fall && en && !d_s2) state_nx = DATA;
      DATA: begin
        if (fall) begin
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end else if (wd_hit) begin
          state_nx = IDLE;
          tmo_now  = 1'b1;
        end
      end
      PARITY: begin
        if (fall) state_nx = STOP;
        else if (wd_hit) begin
          state_nx = IDLE;
          tmo_now  = 1'b1;
        end
      end
      STOP: begin
        if (fall) begin
          state_nx = IDLE;
          push     = 1'b1;
        end else if (wd_hit) begin
          state_nx = IDLE;
          tmo_now  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      timeout <= tmo_now;
      if (state == IDLE || fall)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WDW'(1);
      if (state == IDLE)
        bit_cnt <= '0;
      else if (state == DATA && fall) begin
        shreg   <= {d_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && fall)
        par_bit <= d_s2;
    end
  end

  assign busy = (state != IDLE);
  assign pop  = rx_valid & rx_ready;

`ifdef PS2_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, do_push;

  assign full    = (count == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count   <= count + LW'(do_push) - LW'(pop);
      overrun <= push & full & ~pop;
    end
  end

  assign rx_valid = (count != '0);
  assign head     = mem[rd_ptr];
  assign level    = count;
`else
  logic [9:0] hold;
  logic       hold_v, do_push;

  assign do_push = push & (~hold_v | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      hold_v  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        hold   <= push_entry;
        hold_v <= 1'b1;
      end else if (pop) begin
        hold_v <= 1'b0;
      end
      overrun <= push & hold_v & ~pop;
    end
  end

  assign rx_valid = hold_v;
  assign head     = hold;
  assign level    = LW'(hold_v);
`endif

  assign rx_data       = rx_valid ? head[9:2] : 8'h00;
  assign rx_parity_err = rx_valid & head[1];
  assign rx_frame_err  = rx_valid & head[0];

endmodule
